// File: rtl/rv32i_pkg.sv
// Shared RV32I types and constants: data-path width and data-cache arbiter enums.
// Pure declarations, no logic.
// No flow control.
package rv32i_pkg;

  localparam int XLEN           = 32;
  localparam int ArbStarveLimit = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_CORE, ARB_EXT} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_EXT} arb_owner_e;

endpackage

// File: rtl/d_cache_arb_rsp.sv
// Response steering: remembers which requester issued last cycle's load and routes cache data to it.
// Latency: rvalid/rdata one cycle after the load grant.
// No backpressure; one response per cycle and requesters always accept it.
module d_cache_arb_rsp
  import rv32i_pkg::*;
#(
  parameter int DPW = XLEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           core_rd,
  input  logic           ext_rd,
  input  logic [DPW-1:0] mem_rd_i,
  output logic           core_rvalid_o,
  output logic [DPW-1:0] core_rdata_o,
  output logic           ext_rvalid_o,
  output logic [DPW-1:0] ext_rdata_o
);

  arb_owner_e rsp_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner <= OWN_NONE;
    end else if (core_rd) begin
      rsp_owner <= OWN_CORE;
    end else if (ext_rd) begin
      rsp_owner <= OWN_EXT;
    end else begin
      rsp_owner <= OWN_NONE;
    end
  end

  // Data is zeroed on the idle port so nothing stale leaks to the wrong requester.
  assign core_rvalid_o = (rsp_owner == OWN_CORE);
  assign ext_rvalid_o  = (rsp_owner == OWN_EXT);
  assign core_rdata_o  = core_rvalid_o ? mem_rd_i : '0;
  assign ext_rdata_o   = ext_rvalid_o  ? mem_rd_i : '0;

endmodule

// File: rtl/d_cache_arbiter.sv
// Shares the single-port data cache between CORE and EXT; CORE-first with an EXT starvation guard
// (round-robin when D_CACHE_ARB_RR_EN is defined). Latency: grant and cache drive same cycle, load data +1.
// Backpressure: a requester holds its request until its grant; core_stall_o flags an ungranted CORE request.
module d_cache_arbiter
  import rv32i_pkg::*;
#(
  parameter int DPW          = XLEN,
  parameter int STARVE_LIMIT = ArbStarveLimit,
  parameter int CNT_W        = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           core_req_i,
  input  logic           core_we_i,
  input  logic [DPW-1:0] core_addr_i,
  input  logic [DPW-1:0] core_wdata_i,
  output logic           core_gnt_o,
  output logic           core_rvalid_o,
  output logic [DPW-1:0] core_rdata_o,
  input  logic           ext_req_i,
  input  logic           ext_we_i,
  input  logic [DPW-1:0] ext_addr_i,
  input  logic [DPW-1:0] ext_wdata_i,
  output logic           ext_gnt_o,
  output logic           ext_rvalid_o,
  output logic [DPW-1:0] ext_rdata_o,
  output logic           mem_we_o,
  output logic [DPW-1:0] mem_addr_o,
  output logic [DPW-1:0] mem_wd_o,
  input  logic [DPW-1:0] mem_rd_i,
  output logic           core_stall_o
);

  logic           core_gnt;
  logic           ext_gnt;
  arb_state_e     state;
  logic [DPW-1:0] addr_q;
  logic [DPW-1:0] wd_q;

`ifdef D_CACHE_ARB_RR_EN
  arb_owner_e last_owner;

  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (rst_n) begin
      if (core_req_i && ext_req_i) begin
        core_gnt = (last_owner != OWN_CORE);
        ext_gnt  = (last_owner == OWN_CORE);
      end else begin
        core_gnt = core_req_i;
        ext_gnt  = ext_req_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_EXT;
    end else if (core_gnt) begin
      last_owner <= OWN_CORE;
    end else if (ext_gnt) begin
      last_owner <= OWN_EXT;
    end
  end
`else
  logic [CNT_W-1:0] starve_cnt;
  logic             ext_forced;

  // Grants are gated by rst_n so nothing reaches the cache while reset is held.
  assign ext_forced = ext_req_i && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    core_gnt = rst_n && core_req_i && !ext_forced;
    ext_gnt  = rst_n && ext_req_i && !core_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!ext_req_i || ext_gnt) begin
      starve_cnt <= '0;
    end else if (core_gnt && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      addr_q <= '0;
      wd_q   <= '0;
    end else begin
      if (core_gnt) begin
        state <= ARB_CORE;
      end else if (ext_gnt) begin
        state <= ARB_EXT;
      end else begin
        state <= ARB_IDLE;
      end
      addr_q <= mem_addr_o;
      wd_q   <= mem_wd_o;
    end
  end

  // An idle previous cycle can never have a response in flight.
  always_ff @(posedge clk) begin
    if (rst_n && (state == ARB_IDLE)) begin
      assert (!core_rvalid_o && !ext_rvalid_o);
    end
  end

  always_comb begin
    mem_we_o   = 1'b0;
    mem_addr_o = addr_q;
    mem_wd_o   = wd_q;
    if (core_gnt) begin
      mem_we_o   = core_we_i;
      mem_addr_o = core_addr_i;
      mem_wd_o   = core_wdata_i;
    end else if (ext_gnt) begin
      mem_we_o   = ext_we_i;
      mem_addr_o = ext_addr_i;
      mem_wd_o   = ext_wdata_i;
    end
  end

  assign core_gnt_o   = core_gnt;
  assign ext_gnt_o    = ext_gnt;
  assign core_stall_o = core_req_i && !core_gnt;

  d_cache_arb_rsp #(.DPW(DPW)) u_rsp (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_rd       (core_gnt && !core_we_i),
    .ext_rd        (ext_gnt && !ext_we_i),
    .mem_rd_i      (mem_rd_i),
    .core_rvalid_o (core_rvalid_o),
    .core_rdata_o  (core_rdata_o),
    .ext_rvalid_o  (ext_rvalid_o),
    .ext_rdata_o   (ext_rdata_o)
  );

endmodule

// File: tb/tb_d_cache_arbiter.sv
// Bench for d_cache_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_d_cache_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we, ext_req, ext_we;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
  logic        core_gnt, core_rvalid, ext_gnt, ext_rvalid, mem_we, core_stall;
  logic [31:0] core_rdata, ext_rdata, mem_addr, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_cache_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid), .ext_rdata_o(ext_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd),
    .core_stall_o(core_stall)
  );

  // Cache emulation: 64 words, registered read data.
  logic [31:0] cache [64];
  logic [31:0] shadow [64];

  initial begin
    mem_rd = '0;
    for (int i = 0; i < 64; i++) begin
      cache[i]  = 32'h1000_0000 + i;
      shadow[i] = 32'h1000_0000 + i;
    end
  end

  always @(posedge clk) begin
    mem_rd <= cache[mem_addr[7:2]];
    if (mem_we) cache[mem_addr[7:2]] <= mem_wd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who may go, and which answer is owed to whom next cycle.
  int          m_cnt, m_last, m_pend;  // m_last: 0 core, 1 ext; m_pend: 0 none, 1 core, 2 ext
  logic [31:0] m_pend_data, m_addr, m_wd;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_core_gnt", core_gnt, 0);
      check("rst_ext_gnt", ext_gnt, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_core_rvalid", core_rvalid, 0);
      check("rst_ext_rvalid", ext_rvalid, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wd", mem_wd, 0);
      m_cnt = 0; m_last = 1; m_pend = 0; m_pend_data = '0; m_addr = '0; m_wd = '0;
    end else begin
      bit ext_wins, cg, eg, e_we;
      logic [31:0] e_addr, e_wd;
`ifdef D_CACHE_ARB_RR_EN
      ext_wins = (m_last == 0);
`else
      ext_wins = (m_cnt >= LIMIT);
`endif
      cg = core_req && !(ext_req && ext_wins);
      eg = ext_req && !cg;
      e_we   = cg ? core_we    : (eg ? ext_we    : 1'b0);
      e_addr = cg ? core_addr  : (eg ? ext_addr  : m_addr);
      e_wd   = cg ? core_wdata : (eg ? ext_wdata : m_wd);
      check("core_gnt", core_gnt, cg);
      check("ext_gnt", ext_gnt, eg);
      check("core_stall", core_stall, core_req && !cg);
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wd", mem_wd, e_wd);
      check("core_rvalid", core_rvalid, m_pend == 1);
      check("ext_rvalid", ext_rvalid, m_pend == 2);
      check("core_rdata", core_rdata, (m_pend == 1) ? m_pend_data : 32'h0);
      check("ext_rdata", ext_rdata, (m_pend == 2) ? m_pend_data : 32'h0);
      m_pend = 0;
      if ((cg || eg) && !e_we) begin
        m_pend = cg ? 1 : 2;
        m_pend_data = shadow[e_addr[7:2]];
      end
      if ((cg || eg) && e_we) shadow[e_addr[7:2]] = e_wd;
      m_addr = e_addr;
      m_wd = e_wd;
      if (cg) m_last = 0;
      if (eg) m_last = 1;
      if (!ext_req || eg) m_cnt = 0;
      else if (cg && m_cnt < LIMIT) m_cnt = m_cnt + 1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [31:0] ca,
                       input bit er, input bit ew, input logic [31:0] ea, input logic [31:0] ed);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = 32'h0;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
  endtask

  logic [9:0] gnt_seq, stall_seq, exp_gnt_seq, exp_stall_seq;

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 32'h0, 1, 0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("lit_rst_gnt", {core_gnt, ext_gnt, mem_we}, 3'b000);

    next_cycle(); rst_n = 1'b1;
    @(negedge clk);
    check("lit_first_core_gnt", core_gnt, 1);

    next_cycle(); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

    // EXT preload, then CORE reads it back.
    next_cycle(); drive(0, 0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    check("lit_ext_wr_gnt", ext_gnt, 1);
    check("lit_ext_wr_we", mem_we, 1);
    check("lit_ext_wr_addr", mem_addr, 32'h10);
    next_cycle(); drive(1, 0, 32'h10, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("lit_core_ld_gnt", core_gnt, 1);
    next_cycle(); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("lit_core_ld_rvalid", core_rvalid, 1);
    check("lit_core_ld_rdata", core_rdata, 32'hDEAD_BEEF);

    // Continuous contention.
    for (int i = 0; i < 10; i++) begin
      next_cycle(); drive(1, 0, 32'h20, 1, 0, 32'h24, 32'h0);
      @(negedge clk);
      gnt_seq[i] = core_gnt;
      stall_seq[i] = core_stall;
    end
`ifdef D_CACHE_ARB_RR_EN
    exp_gnt_seq = 10'b1010101010;
    exp_stall_seq = 10'b0101010101;
`else
    exp_gnt_seq = 10'b0111101111;
    exp_stall_seq = 10'b1000010000;
`endif
    check("lit_contention_grants", gnt_seq, exp_gnt_seq);
    check("lit_contention_stall", stall_seq, exp_stall_seq);

    // Back-to-back mixed loads.
    next_cycle(); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    next_cycle(); drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    next_cycle(); drive(0, 0, 32'h0, 1, 0, 32'h4, 32'h0);
    @(negedge clk);
    check("lit_b2b_core_rvalid", core_rvalid, 1);
    check("lit_b2b_core_rdata", core_rdata, 32'h1000_0000);
    check("lit_b2b_ext_quiet", ext_rvalid, 0);
    next_cycle(); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("lit_b2b_ext_rvalid", ext_rvalid, 1);
    check("lit_b2b_ext_rdata", ext_rdata, 32'h1000_0001);
    check("lit_b2b_core_quiet", core_rvalid, 0);

    // Reset lands right after a CORE load grant.
    next_cycle(); drive(1, 0, 32'h8, 0, 0, 32'h0, 32'h0);
    next_cycle(); drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0); rst_n = 1'b0;
    @(negedge clk);
    check("lit_midrst_rvalid", core_rvalid, 0);
    next_cycle(); rst_n = 1'b1;
    @(negedge clk);
    check("lit_after_rst_rvalid", core_rvalid, 0);

    // Randomized traffic, alternating light and heavy load, rare resets.
    for (int c = 0; c < 3000; c++) begin
      int pct;
      pct = ((c / 100) % 2 == 1) ? 92 : 50;
      next_cycle();
      rst_n      = ($urandom_range(0, 299) != 0);
      core_req   = ($urandom_range(0, 99) < pct);
      core_we    = ($urandom_range(0, 2) == 0);
      core_addr  = {24'h0, 8'($urandom)};
      core_wdata = $urandom;
      ext_req    = ($urandom_range(0, 99) < pct);
      ext_we     = ($urandom_range(0, 2) == 0);
      ext_addr   = {24'h0, 8'($urandom)};
      ext_wdata  = $urandom;
    end
    next_cycle(); rst_n = 1'b1; drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_cache_arbiter.md
Name: d_cache_arbiter

Overview:
- Shares the single-port data cache between two requesters: the core load/store path (CORE) and the external loader/debug port (EXT).
- EXT is used for preloading program data and for checking memory contents.
- Per cycle, the block grants one requester and drives the cache's address, write-data and write-enable inputs. It steers the 1-cycle-latency read data back to the requester that issued the read.
- Fixed priority (CORE first) with an EXT starvation guard. A round-robin policy is optional.

Parameters:
- DPW, 32, data/address width (from rv32i_pkg).
- STARVE_LIMIT, 4, number of consecutive CORE grants while EXT waits before EXT is forced.
- CNT_W, 3, width of the starvation counter; must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- core_req_i  in  1  CORE access request; held until granted.
- core_we_i  in  1  1 = store, 0 = load.
- core_addr_i  in  DPW  byte address.
- core_wdata_i  in  DPW  store data.
- core_gnt_o  out  1  CORE access issued this cycle.
- core_rvalid_o  out  1  CORE load data valid.
- core_rdata_o  out  DPW  CORE load data.
- ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_gnt_o, ext_rvalid_o, ext_rdata_o: same as the CORE ports, for EXT.
- mem_we_o  out  1  write enable to the cache.
- mem_addr_o  out  DPW  cache address.
- mem_wd_o  out  DPW  cache write data.
- mem_rd_i  in  DPW  cache read data (registered inside the cache).
- core_stall_o  out  1  core_req_i & ~core_gnt_o.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, starvation counter = 0, rsp_owner = NONE, last_owner = EXT.
  - All grant, rvalid and we outputs = 0; all address/data outputs = 0.
- Grant decision is combinational from the requests and the registered state. At most one grant per cycle; a grant equals acceptance.
- FSM (registered, encodes the owner of the previous cycle):
  - IDLE: no request. CORE: CORE granted last cycle. EXT: EXT granted last cycle.
  - Next state = owner of the current grant, or IDLE if nothing is granted.
- Priority:
  - If only one requester is active, it is granted.
  - If both are active, CORE is granted unless the starvation counter equals STARVE_LIMIT, in which case EXT is granted.
- Starvation counter:
  - Increments on each cycle where CORE is granted while ext_req_i = 1, saturating at STARVE_LIMIT.
  - Clears whenever EXT is granted or ext_req_i = 0.
- Cache drive:
  - On a grant, mem_addr_o, mem_wd_o and mem_we_o come from the granted requester in the same cycle.
  - With no grant, mem_we_o = 0 and address/data hold their last values (the resulting cache read is harmless).
- Read return:
  - A load granted in cycle N is registered into rsp_owner at the end of cycle N.
  - In cycle N+1, the matching *_rvalid_o = 1 and *_rdata_o = mem_rd_i.
  - Back-to-back loads from either requester are supported, one response per cycle.
  - Writes produce no rvalid.
- Boundaries:
  - A grant in the cycle after a write to the same address returns the new data.
  - CORE and EXT writing simultaneously: only the granted one writes; the other stays pending.
  - Reset asserted mid-read: the pending rvalid is dropped and not replayed.
  - A requester deasserting without a grant is legal; nothing is issued.
- Unaligned addresses are passed through unchanged; the cache handles byte lanes.

Optional Feature:
- Macro: D_CACHE_ARB_RR_EN.
- Defined:
  - When both requesters are active, grant the one that is not last_owner (round-robin).
  - The starvation counter is removed; STARVE_LIMIT is ignored.
  - last_owner updates on every grant.
- Undefined: fixed priority plus starvation guard, as above.

Decomposition:
- rv32i_pkg gains:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_CORE, ARB_EXT} arb_state_e.
  - typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_EXT} arb_owner_e.
  - localparam ArbStarveLimit = 4.
- One sub-module: d_cache_arb_rsp, the response-steering register (rsp_owner flop plus rdata/rvalid demux).

Test Plan:
- Reset: hold rst_n = 0 with both requests = 1 → all gnt/rvalid/mem_we_o = 0. Release → CORE granted first cycle.
- EXT preload:
  - EXT writes 0xDEADBEEF @0x10 → ext_gnt_o = 1, mem_we_o = 1, mem_addr_o = 0x10.
  - CORE then loads 0x10 → core_rvalid_o = 1 with core_rdata_o = 0xDEADBEEF one cycle after the grant.
- Contention: both request continuous loads → CORE granted 4 cycles, EXT granted on the 5th, pattern repeats. With D_CACHE_ARB_RR_EN: grants alternate CORE, EXT, CORE...
- Back-to-back mixed reads:
  - CORE loads @0x0, EXT loads @0x4 in consecutive cycles → rvalids in consecutive cycles to the correct owner.
  - No rvalid goes to the wrong port.
- Reset mid-op: assert rst_n = 0 in the cycle after a CORE load grant → core_rvalid_o stays 0; state returns to IDLE.
- Stall: CORE requests while the starvation counter forces EXT → core_stall_o = 1 for exactly that cycle; the CORE request is granted next cycle.
